cp_loop_ctrl: RTL and testbench

CP_LOOP_CTRL -- requirements
Module: cp_loop_ctrl

---
 rtl/cp_pkg.sv | 15 +
 rtl/cp_ptr_reg.sv | 36 +++
 rtl/cp_loop_ctrl.sv | 105 ++++++++++
 tb/tb_cp_loop_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp_pkg.sv
// Shared types and default widths for the CP pointer loop controller and its pointer register.
package cp_pkg;

  localparam int DEF_PTR_W = 4;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } cp_state_t;

endpackage

// File: rtl/cp_ptr_reg.sv
// CP pointer register: write, increment, or restore to the base captured on a write made from zero.
// One-cycle update latency; no backpressure, strobes are acted on the cycle they are seen.
module cp_ptr_reg
  import cp_pkg::*;
#(
  parameter int PTR_W = DEF_PTR_W
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             cp_wen,
  input  logic [PTR_W-1:0] cp_bus,
  input  logic             cp_inc,
  input  logic             cp_rst,
  output logic [PTR_W-1:0] cp_val
);

  localparam logic [PTR_W-1:0] ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [PTR_W-1:0] base_q;

  // The restore base is only captured when the register is written while holding zero.
  always_ff @(posedge Clk) begin
    if (RST) begin
      cp_val <= '0;
      base_q <= '0;
    end else if (cp_wen) begin
      cp_val <= cp_bus;
      if (cp_val == '0) base_q <= cp_bus;
    end else if (cp_inc) begin
      cp_val <= cp_val + ONE;
    end else if (cp_rst) begin
      cp_val <= base_q;
    end
  end

endmodule

// File: rtl/cp_loop_ctrl.sv
// Loop controller sweeping an external pointer register from base to limit for a number of passes.
// Strobes follow state/adv combinationally; adv is the only flow control and is honoured only in RUN.
module cp_loop_ctrl
  import cp_pkg::*;
#(
  parameter int PTR_W = DEF_PTR_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             start,
  input  logic [PTR_W-1:0] base,
  input  logic [PTR_W-1:0] limit,
  input  logic [CNT_W-1:0] passes,
  input  logic             adv,
  input  logic [PTR_W-1:0] cp_val,
  output logic             cp_wen,
  output logic [PTR_W-1:0] cp_bus,
  output logic             cp_inc,
  output logic             cp_rst,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt
);

  localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

  cp_state_t        state;
  logic [PTR_W-1:0] base_r;
  logic [PTR_W-1:0] limit_r;
  logic [CNT_W-1:0] passes_r;

  logic [CNT_W:0]   eff_passes;
  logic [CNT_W:0]   cnt_plus1;
  logic [CNT_W-1:0] cnt_sat;
  logic             at_limit;
  logic             last_pass;

  // A pass count of zero runs once; the compare is one bit wider so it cannot wrap.
  assign eff_passes = (passes_r == '0) ? CNT_ONE : {1'b0, passes_r};
  assign cnt_plus1  = {1'b0, pass_cnt} + CNT_ONE;
  assign cnt_sat    = (pass_cnt == '1) ? pass_cnt : cnt_plus1[CNT_W-1:0];
  assign at_limit   = (cp_val == limit_r);
  assign last_pass  = !(cnt_plus1 < eff_passes);

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_comb begin
    cp_wen = 1'b0;
    cp_bus = '0;
    cp_inc = 1'b0;
    cp_rst = 1'b0;
    if (!RST) begin
      case (state)
        ST_CLEAR: cp_wen = 1'b1;
        ST_LOAD: begin
          cp_wen = 1'b1;
          cp_bus = base_r;
        end
        ST_RUN: begin
          if (adv) begin
            if (!at_limit)       cp_inc = 1'b1;
            else if (!last_pass) cp_rst = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      state    <= ST_IDLE;
      base_r   <= '0;
      limit_r  <= '0;
      passes_r <= '0;
      pass_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_r   <= base;
            limit_r  <= limit;
            passes_r <= passes;
            pass_cnt <= '0;
            // A nonzero pointer must pass through zero so the register re-captures its base.
            state    <= (cp_val != '0) ? ST_CLEAR : ST_LOAD;
          end
        end
        ST_CLEAR: state <= ST_LOAD;
        ST_LOAD:  state <= ST_RUN;
        ST_RUN: begin
          if (adv && at_limit) begin
            pass_cnt <= cnt_sat;
            if (last_pass) state <= ST_DONE;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cp_loop_ctrl.sv
// Directed bench: loop controller driving the CP pointer register with its output fed back.
module tb_cp_loop_ctrl;
  import cp_pkg::*;

  localparam int PTR_W = 4;
  localparam int CNT_W = 4;

  logic             Clk;
  logic             RST;
  logic             ptr_rst;
  logic             start;
  logic [PTR_W-1:0] base;
  logic [PTR_W-1:0] limit;
  logic [CNT_W-1:0] passes;
  logic             adv;
  logic [PTR_W-1:0] cp_val;
  logic             cp_wen;
  logic [PTR_W-1:0] cp_bus;
  logic             cp_inc;
  logic             cp_rst;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;

  int nchecks = 0;
  int nerr    = 0;
  int rst_seen;
  int wrap_seq [8] = '{14, 15, 0, 1, 14, 15, 0, 1};

  cp_loop_ctrl #(.PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .RST(RST), .start(start), .base(base), .limit(limit),
    .passes(passes), .adv(adv), .cp_val(cp_val), .cp_wen(cp_wen),
    .cp_bus(cp_bus), .cp_inc(cp_inc), .cp_rst(cp_rst), .busy(busy),
    .done(done), .pass_cnt(pass_cnt)
  );

  cp_ptr_reg #(.PTR_W(PTR_W)) ptr (
    .Clk(Clk), .RST(ptr_rst), .cp_wen(cp_wen), .cp_bus(cp_bus),
    .cp_inc(cp_inc), .cp_rst(cp_rst), .cp_val(cp_val)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic go(input logic [PTR_W-1:0] b, input logic [PTR_W-1:0] l,
                    input logic [CNT_W-1:0] p);
    start  = 1'b1;
    base   = b;
    limit  = l;
    passes = p;
  endtask

  // Strobe exclusivity and idle bus, sampled mid-cycle throughout the run.
  always @(negedge Clk) begin
    chk("strobe_excl", 32'((cp_wen & cp_inc) | (cp_wen & cp_rst) | (cp_inc & cp_rst)), 0);
    if (!cp_wen) chk("bus_idle", 32'(cp_bus), 0);
  end

  initial begin
    RST = 1'b1; ptr_rst = 1'b1; start = 1'b0; adv = 1'b0;
    base = '0; limit = '0; passes = '0;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", pass_cnt, 0);
    chk("rst_wen", cp_wen, 0);
    RST = 1'b0; ptr_rst = 1'b0;
    cyc();

    // Single pass from a zero pointer goes straight to LOAD.
    go(3, 5, 1); adv = 1'b1; #1;
    chk("idle_adv_ignored", cp_inc, 0);
    cyc(); start = 1'b0;
    chk("s1_load_wen", cp_wen, 1);
    chk("s1_load_bus", cp_bus, 3);
    chk("s1_busy", busy, 1);
    cyc();
    chk("s1_val3", cp_val, 3);
    chk("s1_inc_a", cp_inc, 1);
    cyc();
    chk("s1_inc_b", cp_inc, 1);
    cyc();
    chk("s1_val5", cp_val, 5);
    chk("s1_noinc", cp_inc, 0);
    chk("s1_norst", cp_rst, 0);
    cyc(); adv = 1'b0;
    chk("s1_done", done, 1);
    chk("s1_cnt", pass_cnt, 1);
    chk("s1_final", cp_val, 5);
    cyc();
    chk("s1_idle_done", done, 0);
    chk("s1_idle_busy", busy, 0);
    chk("s1_cnt_hold", pass_cnt, 1);

    // Park the pointer at 9 to provide a stale value.
    go(9, 9, 1); adv = 1'b1;
    cyc(); start = 1'b0;
    cyc(); cyc(); cyc(); adv = 1'b0;
    cyc();
    chk("s2_stale9", cp_val, 9);

    go(2, 3, 2);
    cyc(); start = 1'b0;
    chk("s2_clear_wen", cp_wen, 1);
    chk("s2_clear_bus", cp_bus, 0);
    cyc();
    chk("s2_cleared", cp_val, 0);
    chk("s2_load_bus", cp_bus, 2);
    cyc();
    chk("s2_val2", cp_val, 2);
    chk("s2_hold_inc", cp_inc, 0);
    chk("s2_hold_rst", cp_rst, 0);
    adv = 1'b1; #1;
    chk("s2_inc", cp_inc, 1);
    cyc();
    chk("s2_rst", cp_rst, 1);
    cyc();
    chk("s2_restored", cp_val, 2);
    chk("s2_cnt1", pass_cnt, 1);
    cyc();
    chk("s2_last_norst", cp_rst, 0);
    cyc(); adv = 1'b0;
    chk("s2_done", done, 1);
    chk("s2_cnt2", pass_cnt, 2);
    cyc();

    // Two passes wrapping through 15 and 0.
    go(14, 1, 2); adv = 1'b1;
    cyc(); start = 1'b0;
    chk("s3_clear_bus", cp_bus, 0);
    cyc();
    chk("s3_load_bus", cp_bus, 14);
    rst_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("s3_seq", cp_val, wrap_seq[i]);
      if (cp_rst) rst_seen++;
    end
    cyc(); adv = 1'b0;
    chk("s3_rst_count", rst_seen, 1);
    chk("s3_done", done, 1);
    chk("s3_cnt", pass_cnt, 2);
    cyc();

    // base == limit with passes = 0 finishes on the first adv.
    go(7, 7, 0);
    cyc(); start = 1'b0;
    cyc();
    chk("s4_load_bus", cp_bus, 7);
    cyc();
    chk("s4_val7", cp_val, 7);
    adv = 1'b1; #1;
    chk("s4_noinc", cp_inc, 0);
    chk("s4_norst", cp_rst, 0);
    cyc(); adv = 1'b0;
    chk("s4_done", done, 1);
    chk("s4_cnt", pass_cnt, 1);
    cyc();

    // A start during RUN must not disturb the latched limit/passes.
    go(1, 4, 1);
    cyc(); start = 1'b0;
    cyc(); cyc();
    chk("s5_val1", cp_val, 1);
    go(6, 6, 3);
    cyc(); start = 1'b0; base = '0; limit = '0; passes = '0;
    chk("s5_still_busy", busy, 1);
    chk("s5_no_reload", cp_wen, 0);
    chk("s5_val_kept", cp_val, 1);
    adv = 1'b1;
    cyc(); cyc(); cyc();
    chk("s5_val4", cp_val, 4);
    chk("s5_limit_kept", cp_inc, 0);
    chk("s5_passes_kept", cp_rst, 0);
    cyc(); adv = 1'b0;
    chk("s5_done", done, 1);
    chk("s5_cnt", pass_cnt, 1);
    cyc();

    // Reset arriving mid-run with passes already counted.
    go(2, 2, 3);
    cyc(); start = 1'b0;
    cyc(); cyc();
    chk("s6_val2", cp_val, 2);
    adv = 1'b1; #1;
    chk("s6_rst", cp_rst, 1);
    cyc();
    chk("s6_cnt1", pass_cnt, 1);
    cyc();
    chk("s6_cnt2", pass_cnt, 2);
    RST = 1'b1; #1;
    chk("s6_rstcyc_rst", cp_rst, 0);
    chk("s6_rstcyc_inc", cp_inc, 0);
    chk("s6_rstcyc_wen", cp_wen, 0);
    cyc();
    chk("s6_busy", busy, 0);
    chk("s6_cnt0", pass_cnt, 0);
    chk("s6_done", done, 0);
    RST = 1'b0; #1;
    chk("s6_idle_inc", cp_inc, 0);
    chk("s6_idle_rst", cp_rst, 0);
    chk("s6_ptr_kept", cp_val, 2);
    adv = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
